// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between mem_bus_arbiter, the pipeline requesters and the memory bus.
// With ARB_TIMEOUT_EN defined the bundle also carries bus_err.
interface mem_bus_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_wen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    logic        busy;
`ifdef ARB_TIMEOUT_EN
    logic        bus_err;

    modport master (
        input  inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output bus_req, bus_wr, bus_wen, bus_addr, bus_wdata, busy, bus_err
    );

    modport slave (
        output inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  bus_req, bus_wr, bus_wen, bus_addr, bus_wdata, busy, bus_err
    );
`else
    modport master (
        input  inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output bus_req, bus_wr, bus_wen, bus_addr, bus_wdata, busy
    );

    modport slave (
        output inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  bus_req, bus_wr, bus_wen, bus_addr, bus_wdata, busy
    );
`endif
endinterface

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding arbiter sharing one memory bus between fetch and data ports.
// Data has priority with a fetch starvation guard; ARB_TIMEOUT_EN adds a WAIT watchdog.
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic             clk,
    input logic             rst,
    mem_bus_arbiter_if.master port
);

    typedef enum logic [1:0] {StIdle, StAddr, StWait} state_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    state_e      state_q;
    logic        owner_q;  // 0 = inst, 1 = data
    logic [3:0]  wen_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  starve_q;
    logic        bus_req_q;
    logic        bus_wr_q;

    logic grant_inst;
    logic grant_data;
    logic timeout;
    logic resp_fire;

    assign grant_inst = port.inst_req && (!port.data_req || starve_q == StarveMax);
    assign grant_data = port.data_req && !grant_inst;

`ifdef ARB_TIMEOUT_EN
    logic [15:0] wait_cnt_q;

    assign timeout = (state_q == StWait) && !port.bus_data_ok &&
                     (wait_cnt_q == 16'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else if (state_q == StAddr) begin
            wait_cnt_q <= '0;
        end else if (state_q == StWait && !port.bus_data_ok && !timeout) begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
        end
    end

    assign port.bus_err = timeout;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |32'(TIMEOUT_CYCLES);
    assign timeout = 1'b0;
`endif

    assign resp_fire = (state_q == StWait) && (port.bus_data_ok || timeout);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            wen_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            starve_q  <= '0;
            bus_req_q <= 1'b0;
            bus_wr_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_inst) begin
                        owner_q   <= 1'b0;
                        wen_q     <= '0;
                        addr_q    <= port.inst_addr;
                        wdata_q   <= '0;
                        bus_wr_q  <= 1'b0;
                        bus_req_q <= 1'b1;
                        starve_q  <= '0;
                        state_q   <= StAddr;
                    end else if (grant_data) begin
                        owner_q   <= 1'b1;
                        wen_q     <= port.data_wen;
                        addr_q    <= port.data_addr;
                        wdata_q   <= port.data_wdata;
                        bus_wr_q  <= |port.data_wen;
                        bus_req_q <= 1'b1;
                        // Count only data grants that made a waiting fetch lose.
                        if (!port.inst_req) begin
                            starve_q <= '0;
                        end else if (starve_q != StarveMax) begin
                            starve_q <= starve_q + 4'd1;
                        end
                        state_q   <= StAddr;
                    end
                end
                StAddr: begin
                    if (port.bus_addr_ok) begin
                        bus_req_q <= 1'b0;
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    if (resp_fire) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    bus_req_q <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    assign port.bus_req   = bus_req_q;
    assign port.bus_wr    = bus_wr_q;
    assign port.bus_wen   = wen_q;
    assign port.bus_addr  = addr_q;
    assign port.bus_wdata = wdata_q;
    assign port.busy      = (state_q != StIdle);

    assign port.inst_addr_ok = (state_q == StAddr) && port.bus_addr_ok && !owner_q;
    assign port.data_addr_ok = (state_q == StAddr) && port.bus_addr_ok && owner_q;
    assign port.inst_data_ok = resp_fire && !owner_q;
    assign port.data_data_ok = resp_fire && owner_q;

    // A watchdog completion returns zero data rather than whatever is on the bus.
    assign port.inst_rdata = (resp_fire && !owner_q && !timeout) ? port.bus_rdata : '0;
    assign port.data_rdata = (resp_fire && owner_q && !timeout) ? port.bus_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (STARVE_LIMIT=4, TIMEOUT_CYCLES=8).
// The watchdog scenario runs only when ARB_TIMEOUT_EN is defined.
module tb_mem_bus_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_bus_arbiter_if ab();

    mem_bus_arbiter #(
        .STARVE_LIMIT  (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .port(ab.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got hang want finish");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ab.inst_req    = 1'b0;
        ab.inst_addr   = '0;
        ab.data_req    = 1'b0;
        ab.data_wen    = '0;
        ab.data_addr   = '0;
        ab.data_wdata  = '0;
        ab.bus_addr_ok = 1'b0;
        ab.bus_data_ok = 1'b0;
        ab.bus_rdata   = '0;
    endtask

    // Runs with both requests and both bus acks held; records grant order (1 = data).
    task automatic run_grants(input int n, output logic [15:0] seq, output int got);
        got = 0;
        seq = '0;
        for (int c = 0; c < n * 3 + 6 && got < n; c++) begin
            @(negedge clk);
            if (ab.data_addr_ok) begin
                seq[got] = 1'b1;
                got++;
            end else if (ab.inst_addr_ok) begin
                seq[got] = 1'b0;
                got++;
            end
            if (got < n) step();
        end
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        ab.inst_req    = 1'b1;
        ab.bus_data_ok = 1'b1;
        ab.bus_rdata   = 32'hFFFF_FFFF;
        #3;
        checks++;
        if ({ab.busy, ab.bus_req, ab.bus_wr, ab.inst_addr_ok, ab.inst_data_ok,
             ab.data_addr_ok, ab.data_data_ok} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000000", {ab.busy, ab.bus_req, ab.bus_wr,
                     ab.inst_addr_ok, ab.inst_data_ok, ab.data_addr_ok, ab.data_data_ok});
        end
        step();
        step();
        checks++;
        if ({ab.bus_wen, ab.bus_addr, ab.bus_wdata, ab.inst_rdata, ab.data_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_payload: got wen=%h addr=%h wdata=%h irdata=%h drdata=%h want 0",
                     ab.bus_wen, ab.bus_addr, ab.bus_wdata, ab.inst_rdata, ab.data_rdata);
        end
        checks++;
        if (ab.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold_busy: got %b want 0", ab.busy);
        end
        idle_inputs();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_fetch;
        ab.inst_req  = 1'b1;
        ab.inst_addr = 32'hBFC0_0000;
        @(negedge clk);
        checks++;
        if ({ab.busy, ab.bus_req, ab.inst_addr_ok} !== 3'b000) begin
            errors++;
            $display("FAIL fetch_c1: got busy/req/aok=%b want 000",
                     {ab.busy, ab.bus_req, ab.inst_addr_ok});
        end
        step();
        ab.bus_addr_ok = 1'b1;
        @(negedge clk);
        checks++;
        if ({ab.bus_req, ab.inst_addr_ok, ab.data_addr_ok, ab.bus_wr} !== 4'b1100) begin
            errors++;
            $display("FAIL fetch_c2_flags: got req/iaok/daok/wr=%b want 1100",
                     {ab.bus_req, ab.inst_addr_ok, ab.data_addr_ok, ab.bus_wr});
        end
        checks++;
        if (ab.bus_addr !== 32'hBFC0_0000) begin
            errors++;
            $display("FAIL fetch_bus_addr: got %h want bfc00000", ab.bus_addr);
        end
        step();
        ab.inst_req    = 1'b0;
        ab.bus_addr_ok = 1'b0;
        ab.bus_data_ok = 1'b1;
        ab.bus_rdata   = 32'h3C08_BFAF;
        @(negedge clk);
        checks++;
        if ({ab.bus_req, ab.inst_data_ok, ab.data_data_ok, ab.busy} !== 4'b0101) begin
            errors++;
            $display("FAIL fetch_c3_flags: got req/idok/ddok/busy=%b want 0101",
                     {ab.bus_req, ab.inst_data_ok, ab.data_data_ok, ab.busy});
        end
        checks++;
        if (ab.inst_rdata !== 32'h3C08_BFAF || ab.data_rdata !== 32'h0) begin
            errors++;
            $display("FAIL fetch_rdata: got inst=%h data=%h want 3c08bfaf/00000000",
                     ab.inst_rdata, ab.data_rdata);
        end
        step();
        ab.bus_data_ok = 1'b0;
        @(negedge clk);
        checks++;
        if ({ab.busy, ab.inst_data_ok} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_done: got busy/idok=%b want 00", {ab.busy, ab.inst_data_ok});
        end
        step();
    endtask

    task automatic test_byte_store;
        int pulses;
        pulses = 0;
        ab.data_req   = 1'b1;
        ab.data_wen   = 4'b0100;
        ab.data_addr  = 32'h8000_0002;
        ab.data_wdata = 32'h00AB_0000;
        step();
        ab.bus_addr_ok = 1'b1;
        @(negedge clk);
        checks++;
        if ({ab.bus_req, ab.bus_wr, ab.bus_wen} !== 6'b11_0100) begin
            errors++;
            $display("FAIL store_bus_ctl: got req/wr/wen=%b want 110100",
                     {ab.bus_req, ab.bus_wr, ab.bus_wen});
        end
        checks++;
        if (ab.bus_wdata !== 32'h00AB_0000 || ab.bus_addr !== 32'h8000_0002) begin
            errors++;
            $display("FAIL store_bus_data: got wdata=%h addr=%h want 00ab0000/80000002",
                     ab.bus_wdata, ab.bus_addr);
        end
        checks++;
        if ({ab.data_addr_ok, ab.inst_addr_ok} !== 2'b10) begin
            errors++;
            $display("FAIL store_addr_ok: got daok/iaok=%b want 10",
                     {ab.data_addr_ok, ab.inst_addr_ok});
        end
        step();
        ab.data_req    = 1'b0;
        ab.bus_addr_ok = 1'b0;
        ab.bus_data_ok = 1'b1;
        ab.bus_rdata   = 32'h1234_5678;
        @(negedge clk);
        if (ab.data_data_ok) pulses++;
        checks++;
        if (ab.data_rdata !== 32'h1234_5678 || ab.inst_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL store_resp: got drdata=%h idok=%b want 12345678/0",
                     ab.data_rdata, ab.inst_data_ok);
        end
        step();
        ab.bus_data_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ab.data_data_ok) pulses++;
            step();
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL store_pulses: got %0d data_data_ok pulses want 1", pulses);
        end
    endtask

    task automatic test_slow_bus;
        int req_cycles;
        int aok;
        int dok;
        int busy_low;
        int early_dok;
        req_cycles = 0;
        aok = 0;
        dok = 0;
        busy_low = 0;
        early_dok = 0;
        ab.data_req  = 1'b1;
        ab.data_wen  = 4'b0000;
        ab.data_addr = 32'h0000_0100;
        step();
        for (int i = 0; i < 6; i++) begin
            ab.bus_addr_ok = (i == 5);
            ab.bus_data_ok = (i < 5);  // must be ignored while in ADDR
            @(negedge clk);
            if (ab.bus_req) req_cycles++;
            if (ab.data_addr_ok) aok++;
            if (ab.data_data_ok) early_dok++;
            if (!ab.busy) busy_low++;
            step();
        end
        ab.data_req    = 1'b0;
        ab.bus_addr_ok = 1'b0;
        ab.bus_rdata   = 32'hCAFE_F00D;
        for (int j = 0; j < 8; j++) begin
            ab.bus_data_ok = (j == 7);
            @(negedge clk);
            if (ab.bus_req) req_cycles++;
            if (!ab.busy) busy_low++;
            if (ab.data_data_ok) begin
                dok++;
                checks++;
                if (ab.data_rdata !== 32'hCAFE_F00D) begin
                    errors++;
                    $display("FAIL slow_rdata: got %h want cafef00d", ab.data_rdata);
                end
            end
            step();
        end
        ab.bus_data_ok = 1'b0;
        @(negedge clk);
        checks++;
        if (req_cycles !== 6) begin
            errors++;
            $display("FAIL slow_req_cycles: got %0d want 6", req_cycles);
        end
        checks++;
        if (aok !== 1 || dok !== 1 || early_dok !== 0) begin
            errors++;
            $display("FAIL slow_pulses: got aok=%0d dok=%0d early_dok=%0d want 1/1/0",
                     aok, dok, early_dok);
        end
        checks++;
        if (busy_low !== 0 || ab.busy !== 1'b0) begin
            errors++;
            $display("FAIL slow_busy: got busy_low=%0d busy_after=%b want 0/0",
                     busy_low, ab.busy);
        end
        step();
    endtask

    task automatic test_starvation;
        logic [15:0] seq;
        logic [15:0] expd;
        int          got;
        expd = 16'h01EF;  // D,D,D,D,I,D,D,D,D,I (bit set = data)
        ab.inst_req    = 1'b1;
        ab.inst_addr   = 32'h0000_1000;
        ab.data_req    = 1'b1;
        ab.data_wen    = 4'b0000;
        ab.data_addr   = 32'h0000_2000;
        ab.bus_addr_ok = 1'b1;
        ab.bus_data_ok = 1'b1;
        ab.bus_rdata   = 32'h5555_AAAA;
        run_grants(10, seq, got);
        checks++;
        if (got !== 10) begin
            errors++;
            $display("FAIL starve_count: got %0d grants want 10", got);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (seq[i] !== expd[i]) begin
                errors++;
                $display("FAIL starve_order[%0d]: got %s want %s", i,
                         seq[i] ? "D" : "I", expd[i] ? "D" : "I");
            end
        end
        ab.inst_req = 1'b0;
        ab.data_req = 1'b0;
        step();
        step();
        ab.bus_addr_ok = 1'b0;
        ab.bus_data_ok = 1'b0;
        @(negedge clk);
        checks++;
        if (ab.busy !== 1'b0) begin
            errors++;
            $display("FAIL starve_idle: got busy=%b want 0", ab.busy);
        end
        step();
    endtask

    task automatic test_reset_mid;
        logic [15:0] seq;
        int          got;
        ab.inst_req    = 1'b1;
        ab.inst_addr   = 32'h0000_3000;
        ab.data_req    = 1'b1;
        ab.data_addr   = 32'h0000_4000;
        ab.bus_addr_ok = 1'b1;
        ab.bus_data_ok = 1'b1;
        run_grants(3, seq, got);
        checks++;
        if (got !== 3 || seq[2:0] !== 3'b111) begin
            errors++;
            $display("FAIL rstmid_pre: got %0d grants seq=%b want 3/111", got, seq[2:0]);
        end
        step();
        rst = 1'b1;
        #1;
        checks++;
        if ({ab.busy, ab.bus_req, ab.data_data_ok, ab.inst_data_ok} !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_async: got busy/req/ddok/idok=%b want 0000",
                     {ab.busy, ab.bus_req, ab.data_data_ok, ab.inst_data_ok});
        end
        step();
        rst = 1'b0;
        run_grants(5, seq, got);
        checks++;
        if (got !== 5 || seq[4:0] !== 5'b01111) begin
            errors++;
            $display("FAIL rstmid_post: got %0d grants seq=%b want 5/01111", got, seq[4:0]);
        end
        ab.inst_req = 1'b0;
        ab.data_req = 1'b0;
        step();
        step();
        ab.bus_addr_ok = 1'b0;
        ab.bus_data_ok = 1'b0;
        @(negedge clk);
        checks++;
        if (ab.busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle: got busy=%b want 0", ab.busy);
        end
        step();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout;
        int fire_idx;
        int err_early;
        fire_idx  = -1;
        err_early = 0;
        ab.data_req  = 1'b1;
        ab.data_wen  = 4'b0000;
        ab.data_addr = 32'h0000_0200;
        ab.bus_rdata = 32'hDEAD_BEEF;
        step();
        ab.bus_addr_ok = 1'b1;
        step();
        ab.data_req    = 1'b0;
        ab.bus_addr_ok = 1'b0;
        for (int i = 0; i < 20 && fire_idx < 0; i++) begin
            @(negedge clk);
            if (ab.data_data_ok) begin
                fire_idx = i;
                checks++;
                if (ab.data_rdata !== 32'h0 || ab.bus_err !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_resp: got rdata=%h bus_err=%b want 00000000/1",
                             ab.data_rdata, ab.bus_err);
                end
            end else begin
                if (ab.bus_err) err_early++;
                step();
            end
        end
        checks++;
        if (fire_idx !== 8 || err_early !== 0) begin
            errors++;
            $display("FAIL timeout_cycle: got fire=%0d early_err=%0d want 8/0",
                     fire_idx, err_early);
        end
        step();
        ab.bus_data_ok = 1'b1;
        @(negedge clk);
        checks++;
        if ({ab.busy, ab.data_data_ok, ab.bus_err} !== 3'b000) begin
            errors++;
            $display("FAIL timeout_late: got busy/ddok/err=%b want 000",
                     {ab.busy, ab.data_data_ok, ab.bus_err});
        end
        ab.bus_data_ok = 1'b0;
        step();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_single_fetch();
        test_byte_store();
        test_slow_bus();
        test_starvation();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
